// File: rtl/uart_packet_ctrl.sv
// uart_packet_ctrl: reads a received UART packet out as one command, then
// writes the client's response (or a timeout response) into the transmit buffer.
`default_nettype none

module uart_packet_ctrl #(
  parameter int         PKT_BYTES      = 5,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] TO_STATUS      = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_full,
  input  logic [7:0]  uart_r_data,
  input  logic        uart_tx_busy,
  output logic [2:0]  uart_address,
  output logic        uart_we,
  output logic [7:0]  uart_w_data,
  output logic        rx_clear,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_arg,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_status,
  input  logic [31:0] rsp_data,
  output logic        rsp_ready,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  localparam int            IW       = $clog2(PKT_BYTES + 1);
  localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_BYTES);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, READ, CLEAR, ISSUE, WAIT_RSP, WRITE_WAIT, WRITE, DONE
  } state_t;

  state_t         state, state_next;
  logic [IW-1:0]  idx, idx_next;
  logic [TW-1:0]  timer, timer_next;
  logic [39:0]    rsp_buf, rsp_buf_next;

  logic [2:0]  address_next;
  logic        we_next, rx_clear_next, cmd_valid_next, rsp_ready_next, busy_next;
  logic [7:0]  w_data_next, opcode_next, timeout_cnt_next;
  logic [31:0] arg_next;

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    timer_next       = timer;
    rsp_buf_next     = rsp_buf;
    address_next     = 3'd0;
    we_next          = 1'b0;
    w_data_next      = uart_w_data;
    rx_clear_next    = 1'b0;
    cmd_valid_next   = cmd_valid;
    opcode_next      = cmd_opcode;
    arg_next         = cmd_arg;
    rsp_ready_next   = rsp_ready;
    timeout_cnt_next = timeout_cnt;

    case (state)
      IDLE: begin
        if (uart_full) begin
          state_next = READ;
          idx_next   = '0;
        end
      end
      READ: begin
        // Read data lags the address by one cycle, so slot idx holds byte idx-1.
        if (idx == IW'(1)) begin
          opcode_next = uart_r_data;
        end else if (idx != '0) begin
          arg_next = {cmd_arg[23:0], uart_r_data};
        end
        if (idx == LAST_IDX) begin
          state_next    = CLEAR;
          rx_clear_next = 1'b1;
        end else begin
          idx_next     = idx + 1'b1;
          address_next = 3'(idx + 1'b1);
        end
      end
      CLEAR: begin
        cmd_valid_next = 1'b1;
        state_next     = ISSUE;
      end
      ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_next = 1'b0;
          rsp_ready_next = 1'b1;
          timer_next     = '0;
          state_next     = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          rsp_buf_next   = {rsp_status, rsp_data};
          rsp_ready_next = 1'b0;
          state_next     = WRITE_WAIT;
        end else if (timer == TMAX) begin
          rsp_buf_next     = {TO_STATUS, cmd_arg};
          rsp_ready_next   = 1'b0;
          timeout_cnt_next = (timeout_cnt == 8'hFF) ? 8'hFF : timeout_cnt + 8'd1;
          state_next       = WRITE_WAIT;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      WRITE_WAIT: begin
        if (!uart_tx_busy) begin
          we_next      = 1'b1;
          address_next = 3'd0;
          w_data_next  = rsp_buf[39:32];
          rsp_buf_next = {rsp_buf[31:0], 8'h00};
          idx_next     = IW'(1);
          state_next   = WRITE;
        end
      end
      WRITE: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          we_next      = 1'b1;
          address_next = 3'(idx);
          w_data_next  = rsp_buf[39:32];
          rsp_buf_next = {rsp_buf[31:0], 8'h00};
          idx_next     = idx + 1'b1;
        end
      end
      DONE: begin
        // Wait for the UART to take the packet so a stale not-busy is not reused.
        if (uart_tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      timer        <= '0;
      rsp_buf      <= '0;
      uart_address <= 3'd0;
      uart_we      <= 1'b0;
      uart_w_data  <= 8'd0;
      rx_clear     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_opcode   <= 8'd0;
      cmd_arg      <= 32'd0;
      rsp_ready    <= 1'b0;
      busy         <= 1'b0;
      timeout_cnt  <= 8'd0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      timer        <= timer_next;
      rsp_buf      <= rsp_buf_next;
      uart_address <= address_next;
      uart_we      <= we_next;
      uart_w_data  <= w_data_next;
      rx_clear     <= rx_clear_next;
      cmd_valid    <= cmd_valid_next;
      cmd_opcode   <= opcode_next;
      cmd_arg      <= arg_next;
      rsp_ready    <= rsp_ready_next;
      busy         <= busy_next;
      timeout_cnt  <= timeout_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_packet_ctrl.sv
// Bench for uart_packet_ctrl: UART buffer model, vector table and a write scoreboard.
`default_nettype none

module tb_uart_packet_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_full = 1'b0;
  logic [7:0]  uart_r_data = 8'd0;
  logic        uart_tx_busy;
  logic [2:0]  uart_address;
  logic        uart_we;
  logic [7:0]  uart_w_data;
  logic        rx_clear;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_arg;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_status = 8'd0;
  logic [31:0] rsp_data = 32'd0;
  logic        rsp_ready;
  logic        busy;
  logic [7:0]  timeout_cnt;

  uart_packet_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .uart_full(uart_full), .uart_r_data(uart_r_data),
    .uart_tx_busy(uart_tx_busy), .uart_address(uart_address), .uart_we(uart_we),
    .uart_w_data(uart_w_data), .rx_clear(rx_clear), .cmd_valid(cmd_valid),
    .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] arg;
    int          ready_hold;
    bit          timeout;
    int          rsp_delay;
    logic [7:0]  st;
    logic [31:0] dat;
    int          busy_hold;
    logic [39:0] exp_pkt;
    int          exp_wait;
    logic [7:0]  exp_to;
  } vec_t;

  typedef struct { int cyc; logic [2:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [2:0] addr; logic [7:0] data; } exp_t;

  wr_t  wr_q[$];
  exp_t exp_q[$];
  int   rd_ptr = 0;
  int   cyc = 0;
  int   rx_clear_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] rx_buf [8];
  logic       busy_force = 1'b0;
  logic       auto_busy = 1'b0;
  int         drain = 0;

  assign uart_tx_busy = busy_force | auto_busy;

  // UART model: registered read port, transmit buffer goes busy after the last byte.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    uart_r_data <= rx_buf[uart_address];
    if (uart_we && uart_address == 3'd4) begin
      auto_busy <= 1'b1;
      drain <= 3;
    end else if (drain > 0) begin
      drain <= drain - 1;
    end else begin
      auto_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (uart_we) wr_q.push_back('{cyc, uart_address, uart_w_data});
    if (rx_clear) rx_clear_cnt <= rx_clear_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {uart_address, uart_we, uart_w_data, rx_clear, cmd_valid, cmd_opcode,
                 rsp_ready, busy, timeout_cnt}, 64'd0);
    check({name, "_arg"}, cmd_arg, 64'd0);
  endtask

  task automatic run_txn(input vec_t v, input bit abort);
    int n;
    int wait_cnt;
    int clr0;
    int prev_cyc;
    bit stable;
    logic [39:0] p;
    exp_t e;
    wr_t g;

    n = 0;
    while ((busy || uart_tx_busy) && n < 100) begin step(); n++; end
    check("idle_before_txn", n < 100, 1);

    rx_buf[0] = v.op;          rx_buf[1] = v.arg[31:24];
    rx_buf[2] = v.arg[23:16];  rx_buf[3] = v.arg[15:8];
    rx_buf[4] = v.arg[7:0];
    p = v.exp_pkt;
    for (int i = 0; i < 5; i++) exp_q.push_back('{3'(i), p[39-8*i -: 8]});
    busy_force = (v.busy_hold > 0);
    cmd_ready  = (v.ready_hold == 0);
    clr0 = rx_clear_cnt;
    uart_full = 1'b1;

    n = 0;
    do begin step(); n++; end while (!cmd_valid && n < 50);
    uart_full = 1'b0;
    check("cmd_latency", n, 8);
    check("cmd_opcode", cmd_opcode, v.op);
    check("cmd_arg", cmd_arg, v.arg);
    check("rx_clear_pulses", rx_clear_cnt - clr0, 1);

    if (v.ready_hold > 0) begin
      stable = 1'b1;
      for (int i = 1; i < v.ready_hold; i++) begin
        step();
        if (!cmd_valid || cmd_opcode != v.op || cmd_arg != v.arg || rsp_ready) stable = 1'b0;
      end
      check("cmd_stable_while_not_ready", stable, 1);
      cmd_ready = 1'b1;
    end
    step();
    cmd_ready = 1'b0;
    check("cmd_valid_dropped", cmd_valid, 0);
    check("rsp_ready_after_cmd", rsp_ready, 1);

    wait_cnt = 1;
    if (!v.timeout) begin
      for (int i = 0; i < v.rsp_delay; i++) begin
        step();
        if (rsp_ready) wait_cnt++;
      end
      rsp_valid = 1'b1; rsp_status = v.st; rsp_data = v.dat;
      step();
      rsp_valid = 1'b0; rsp_status = ~v.st; rsp_data = ~v.dat;
      check("rsp_ready_dropped", rsp_ready, 0);
    end else begin
      n = 0;
      do begin step(); n++; if (rsp_ready) wait_cnt++; end while (rsp_ready && n < 100);
    end
    check("wait_rsp_cycles", wait_cnt, v.exp_wait);

    if (v.busy_hold > 0) begin
      for (int i = 0; i < v.busy_hold; i++) step();
      check("no_write_while_busy", wr_q.size() - rd_ptr, 0);
      busy_force = 1'b0;
    end

    if (abort) begin
      n = 0;
      while ((wr_q.size() - rd_ptr) < 3 && n < 80) begin step(); n++; end
      check("third_write_reached", uart_we && uart_address == 3'd2, 1);
      reset = 1'b1;
      #1;
      check_reset_outputs("reset_mid_write");
      step(); step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("no_write_after_reset", wr_q.size() - rd_ptr, 3);
      check("idle_after_reset", busy, 0);
      rd_ptr = wr_q.size();
      exp_q.delete();
      return;
    end

    n = 0;
    while ((wr_q.size() - rd_ptr) < 5 && n < 80) begin step(); n++; end
    prev_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      if (rd_ptr < wr_q.size()) begin
        g = wr_q[rd_ptr];
        rd_ptr++;
      end else begin
        g = '{-1, 3'd7, 8'h00};
      end
      check("wr_addr", g.addr, e.addr);
      check("wr_data", g.data, e.data);
      if (i > 0) check("wr_consecutive", g.cyc - prev_cyc, 1);
      prev_cyc = g.cyc;
    end

    n = 0;
    while (busy && n < 20) begin step(); n++; end
    check("back_to_idle", busy, 0);
    check("no_extra_writes", wr_q.size() - rd_ptr, 0);
    check("timeout_cnt", timeout_cnt, v.exp_to);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int to_model;

    for (int i = 0; i < 8; i++) rx_buf[i] = 8'h00;
    step(); step();
    check_reset_outputs("reset_state");
    reset = 1'b0;
    step();

    vecs[0] = '{8'h10, 32'hDEADBEEF, 0,  1'b0, 2,  8'h00, 32'h01020304, 0,  40'h00_01020304, 3,  8'd0};
    vecs[1] = '{8'hA5, 32'h11223344, 10, 1'b0, 0,  8'h5A, 32'hCAFEF00D, 0,  40'h5A_CAFEF00D, 1,  8'd0};
    vecs[2] = '{8'h10, 32'hDEADBEEF, 0,  1'b1, 0,  8'h00, 32'h00000000, 0,  40'hFF_DEADBEEF, 16, 8'd1};
    vecs[3] = '{8'h3C, 32'h00000000, 0,  1'b0, 4,  8'h01, 32'hFFFFFFFF, 20, 40'h01_FFFFFFFF, 5,  8'd1};
    vecs[4] = '{8'h77, 32'h89ABCDEF, 0,  1'b0, 15, 8'h00, 32'h13579BDF, 0,  40'h00_13579BDF, 16, 8'd1};
    vecs[5] = '{8'h00, 32'h80000001, 3,  1'b1, 0,  8'h00, 32'h00000000, 0,  40'hFF_80000001, 16, 8'd2};

    // Handshakes while idle must not start anything.
    cmd_ready = 1'b1; rsp_valid = 1'b1;
    step(); step(); step();
    check("idle_ignores_handshakes", {busy, cmd_valid, rsp_ready, uart_we}, 0);
    cmd_ready = 1'b0; rsp_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0);

    to_model = 2;
    for (int k = 0; k < 300; k++) begin
      to_model = (to_model < 255) ? to_model + 1 : 255;
      v = vecs[2];
      v.op = 8'(k);
      v.arg = {8'(k), 8'hA5, 8'(k * 3), 8'h5A};
      v.exp_pkt = {8'hFF, v.arg};
      v.exp_to = 8'(to_model);
      run_txn(v, 1'b0);
    end
    check("timeout_saturated", timeout_cnt, 8'd255);

    run_txn(vecs[0], 1'b1);

    v = vecs[2];
    v.exp_to = 8'd1;
    run_txn(v, 1'b0);
    v = vecs[1];
    v.exp_to = 8'd1;
    run_txn(v, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
